// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory front end: access sizes, LSU FSM states
// and the default word-address width of the 1024-entry data memory.
package mips_mem_pkg;

  localparam int DEFAULT_MEM_AW = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_RD   = 2'd1,
    LSU_WR   = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  // Size 2'b11 is treated as a word, so bit 1 alone marks a word access.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
    if (size[1]) begin
      return offset != 2'b00;
    end
    if (size == SZ_HALF) begin
      return offset[0];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the MEM-stage request/response handshake and the data-memory port.
// The LSU uses the slave view; the pipeline/memory side uses the master view.
interface load_store_unit_if
  import mips_mem_pkg::*;
#(
  parameter int MEM_AW = DEFAULT_MEM_AW
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts/extends a load result from a memory word
// and merges a byte or halfword into an old word for read-modify-write stores.
module lsu_lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    case (size_i)
      SZ_BYTE: load_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_HALF: load_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Each lane takes new data when it falls inside the access, else keeps the old byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;

      always_comb begin
        case (size_i)
          SZ_BYTE: begin
            hit = (offset_i == 2'(gi));
            src = data_i[7:0];
          end
          SZ_HALF: begin
            hit = (offset_i[1] == 1'(gi / 2));
            src = data_i[8*(gi%2) +: 8];
          end
          default: begin
            hit = 1'b1;
            src = data_i[8*gi +: 8];
          end
        endcase
      end

      assign merge_o[8*gi +: 8] = hit ? src : word_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store front end for a word-wide data memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_CHECK_EN to reject misaligned accesses.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_AW = DEFAULT_MEM_AW
)
(
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE = LSU_IDLE;
  localparam logic [1:0] S_RD   = LSU_RD;
  localparam logic [1:0] S_WR   = LSU_WR;
  localparam logic [1:0] S_RESP = LSU_RESP;

  logic [1:0]        state_q,      state_d;
  logic              store_q,      store_d;
  logic              unsigned_q,   unsigned_d;
  logic [1:0]        size_q,       size_d;
  logic [1:0]        off_q,        off_d;
  logic [31:0]       wdata_q,      wdata_d;
  logic [MEM_AW-1:0] mem_addr_q,   mem_addr_d;
  logic [31:0]       mem_wdata_q,  mem_wdata_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q,   resp_err_d;

  logic        accept;
  logic        misaligned;
  logic [31:0] ld_data;
  logic [31:0] st_word;
  logic        unused_addr_bits;

  // Upper address bits fall outside the memory and wrap away.
  assign unused_addr_bits = ^bus.req_addr[31:MEM_AW+2];

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = lsu_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign bus.req_ready  = (state_q == S_IDLE) || (state_q == S_RESP);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.mem_we     = (state_q == S_WR);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  assign accept = bus.req_valid && bus.req_ready;

  lsu_lane_align u_align (
    .word_i     (bus.mem_rdata),
    .data_i     (wdata_q),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .load_o     (ld_data),
    .merge_o    (st_word)
  );

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    unsigned_d   = unsigned_q;
    size_d       = size_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_RD: begin
        if (store_q) begin
          mem_wdata_d = st_word;
          state_d     = S_WR;
        end else begin
          resp_rdata_d = ld_data;
          resp_err_d   = 1'b0;
          state_d      = S_RESP;
        end
      end
      S_WR: begin
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          store_d    = bus.req_store;
          unsigned_d = bus.req_unsigned;
          size_d     = bus.req_size;
          off_d      = bus.req_addr[1:0];
          wdata_d    = bus.req_wdata;
          if (misaligned) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
            state_d      = S_RESP;
          end else begin
            mem_addr_d = bus.req_addr[MEM_AW+1:2];
            // Whole-word stores skip the read; everything else reads first.
            if (bus.req_store && bus.req_size[1]) begin
              mem_wdata_d = bus.req_wdata;
              state_d     = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= SZ_BYTE;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      unsigned_q   <= unsigned_d;
      size_q       <= size_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule
